// File: rtl/mac_drain_if.sv
// mac_drain_if: row bus between the systolic MAC array and the drain buffer,
// plus the downstream valid/ready side of the drain buffer.
//
// Signals:
//   mac_op    - array bottom-row outputs, column k at [(k+1)*VERTICAL_BW-1 : k*VERTICAL_BW]
//   in_valid  - column 0 of mac_op carries the first element of a row this cycle
//   out_data  - aligned row at the FIFO head (zero when empty)
//   out_valid - out_data holds the FIFO head
//   out_ready - downstream accepts out_data this cycle
//
// Handshake: a row transfers downstream on every rising edge where
// out_valid && out_ready. While out_valid=1 and out_ready=0, out_valid and
// out_data hold their values. out_valid does not depend on out_ready.
//
// Modports: master = array/downstream side (drives mac_op, in_valid, out_ready),
//           slave  = mac_drain.
interface mac_drain_if #(
  parameter int ARR_SIZE    = 4,
  parameter int VERTICAL_BW = 32
);
  localparam int DW = ARR_SIZE * VERTICAL_BW;

  logic [DW-1:0] mac_op;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output mac_op, in_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  mac_op, in_valid, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/mac_drain.sv
// mac_drain: de-skews the bottom row of the systolic MAC array (column k
// arrives k cycles after column 0) into full-width rows, buffers them in a
// DEPTH-row FIFO and presents them over a valid/ready handshake.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-high reset
//   bus      - mac_drain_if.slave (mac_op/in_valid in, out_data/out_valid out,
//              out_ready in)
//   level    - rows currently held in the FIFO (0..DEPTH)
//   overflow - sticky, a completed row was dropped because the FIFO was full
//
// Requires ARR_SIZE >= 2 and DEPTH a power of two >= 2.
module mac_drain #(
  parameter  int ARR_SIZE    = 4,
  parameter  int VERTICAL_BW = 32,
  parameter  int DEPTH       = 4,
  localparam int DW          = ARR_SIZE * VERTICAL_BW,
  localparam int AW          = $clog2(DEPTH),
  localparam int LW          = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  mac_drain_if.slave      bus,
  output logic [LW-1:0]   level,
  output logic            overflow
);

  // ---------------------------------------------------------------------------
  // De-skew. Column k sits ARR_SIZE-1-k stages deep so that every column of a
  // row lines up with the last column, which is taken straight off mac_op.
  // Data stages carry no reset: they are only ever qualified by row_valid.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] aligned;

  for (genvar k = 0; k < ARR_SIZE; k++) begin : g_col
    if (k == ARR_SIZE - 1) begin : g_direct
      assign aligned[k*VERTICAL_BW +: VERTICAL_BW] = bus.mac_op[k*VERTICAL_BW +: VERTICAL_BW];
    end else begin : g_pipe
      localparam int N = ARR_SIZE - 1 - k;
      logic [VERTICAL_BW-1:0] stage [N];

      always_ff @(posedge clk) begin
        stage[0] <= bus.mac_op[k*VERTICAL_BW +: VERTICAL_BW];
        for (int j = 1; j < N; j++) begin
          stage[j] <= stage[j-1];
        end
      end

      assign aligned[k*VERTICAL_BW +: VERTICAL_BW] = stage[N-1];
    end
  end

  // Row marker travels alongside column 0; its tail says "aligned is a row".
  logic [ARR_SIZE-2:0] vpipe;
  logic                row_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= bus.in_valid;
      for (int j = 1; j < ARR_SIZE - 1; j++) begin
        vpipe[j] <= vpipe[j-1];
      end
    end
  end

  assign row_valid = vpipe[ARR_SIZE-2];

  // ---------------------------------------------------------------------------
  // FIFO. A push into a full FIFO is still taken when the head leaves in the
  // same cycle, so streaming with out_ready high never drops rows.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full = (level == LW'(DEPTH));
  assign pop  = bus.out_valid && bus.out_ready;
  assign push = row_valid && (!full || pop);
  assign drop = row_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= aligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Outputs come only from registered state, so they cannot move while the
  // head is waiting on out_ready.
  assign bus.out_valid = (level != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_mac_drain.sv
// Bench for mac_drain: directed scenarios followed by random traffic, each
// cycle checked against a row-level reference (rows in flight, a FIFO queue
// and a sticky overflow flag).
module tb_mac_drain;
  localparam int A  = 4;
  localparam int VB = 32;
  localparam int D  = 4;
  localparam int DW = A * VB;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] level;
  logic          overflow;

  mac_drain_if #(.ARR_SIZE(A), .VERTICAL_BW(VB)) bus ();

  mac_drain #(.ARR_SIZE(A), .VERTICAL_BW(VB), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference state
  logic [DW-1:0] exp_q[$];     // rows held in the FIFO, head first
  int            fl_start[$];  // start cycle of each row still being skewed in
  logic [DW-1:0] fl_row[$];    // the full row for each of those
  bit            m_ovf = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_row(input int base);
    logic [DW-1:0] r;
    for (int k = 0; k < A; k++) r[k*VB +: VB] = VB'(base + k);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_row();
    logic [DW-1:0] r;
    for (int k = 0; k < A; k++) r[k*VB +: VB] = $urandom;
    return r;
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge, advance
  // the reference model, then move past the next rising edge.
  task automatic cycle(input bit iv, input logic [DW-1:0] row, input bit rdy, input bit r);
    logic [DW-1:0] op;
    logic [DW-1:0] comp_row;
    bit            found;
    bit            comp;
    bit            pop;
    bit            push;

    if (!r && iv) begin
      fl_start.push_back(cyc);
      fl_row.push_back(row);
    end
    // Column k on the bus this cycle belongs to the row that started k cycles ago.
    for (int k = 0; k < A; k++) begin
      found = 1'b0;
      op[k*VB +: VB] = $urandom;
      for (int i = 0; i < fl_start.size(); i++) begin
        if (fl_start[i] == cyc - k) begin
          op[k*VB +: VB] = fl_row[i][k*VB +: VB];
          found = 1'b1;
        end
      end
    end
    bus.mac_op    = op;
    bus.in_valid  = iv;
    bus.out_ready = rdy;
    rst           = r;

    @(negedge clk);
    check("out_valid", DW'(bus.out_valid), DW'(exp_q.size() != 0));
    check("out_data",  bus.out_data, (exp_q.size() != 0) ? exp_q[0] : '0);
    check("level",     DW'(level), DW'(exp_q.size()));
    check("overflow",  DW'(overflow), DW'(m_ovf));

    if (r) begin
      exp_q.delete();
      fl_start.delete();
      fl_row.delete();
      m_ovf = 1'b0;
    end else begin
      pop      = (exp_q.size() != 0) && rdy;
      comp     = 1'b0;
      comp_row = '0;
      for (int i = 0; i < fl_start.size(); i++) begin
        if (fl_start[i] + A - 1 == cyc) begin
          comp     = 1'b1;
          comp_row = fl_row[i];
        end
      end
      push = comp && (exp_q.size() < D || pop);
      if (comp && exp_q.size() == D && !pop) m_ovf = 1'b1;
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(comp_row);
      while (fl_start.size() != 0 && fl_start[0] + A - 1 <= cyc) begin
        void'(fl_start.pop_front());
        void'(fl_row.pop_front());
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.mac_op    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Single row: columns 0x1000+k, ready held high
    cycle(1'b1, mk_row(32'h1000), 1'b1, 1'b0);
    idle(8, 1'b1);

    // Eight back-to-back rows, row r column k = r*16+k
    for (int r = 0; r < 8; r++) cycle(1'b1, mk_row(r * 16), 1'b1, 1'b0);
    idle(8, 1'b1);

    // Fill then overflow: five rows into a stalled FIFO, then drain
    for (int r = 0; r < 5; r++) cycle(1'b1, mk_row(32'h300 + r * 16), 1'b0, 1'b0);
    idle(6, 1'b0);
    idle(8, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Push and pop while full: fifth row completes on the first ready cycle
    for (int r = 0; r < 4; r++) cycle(1'b1, mk_row(32'h400 + r * 16), 1'b0, 1'b0);
    cycle(1'b1, mk_row(32'h4f0), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(8, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Backpressure: ready toggles every cycle while rows stream
    for (int r = 0; r < 10; r++) cycle(1'b1, rnd_row(), bit'(r % 2), 1'b0);
    for (int r = 0; r < 20; r++) cycle(1'b0, '0, bit'(r % 2), 1'b0);

    // Reset mid-operation: two rows held, third row two cycles into the skew
    for (int r = 0; r < 2; r++) cycle(1'b1, mk_row(32'h600 + r * 16), 1'b0, 1'b0);
    idle(4, 1'b0);
    cycle(1'b1, mk_row(32'h6f0), 1'b0, 1'b0);
    idle(1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(8, 1'b1);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 1)), rnd_row(),
            bit'($urandom_range(0, 3) != 0), $urandom_range(0, 99) == 0);
    end
    idle(10, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
